// File: rtl/tmds_decoder.sv
// Receive-side TMDS channel decoder: aligns unframed 10-bit words by hunting for
// control tokens, then decodes each symbol to video data or control data.
module tmds_decoder #(
   parameter int CTL_RUN = 8,
   parameter int TIMEOUT = 2048
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] raw,
   output logic [7:0] vd,
   output logic [1:0] cd,
   output logic       vde,
   output logic       locked,
   output logic [3:0] offset,
   output logic [7:0] relock_cnt
);
   localparam int            TW         = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [8:0]    RUN_LOCK   = 9'(CTL_RUN);

   typedef enum logic {S_HUNT = 1'b0, S_LOCKED = 1'b1} state_t;

   state_t        r_state, w_state_nx;
   logic [9:0]    r_raw_d, r_sym, w_win;
   logic [3:0]    r_offset, w_offset_nx;
   logic [TW-1:0] r_timer, w_timer_nx;
   logic [7:0]    r_run, w_run_nx, r_relock, w_relock_nx;
   logic [8:0]    w_run_inc;
   logic [7:0]    r_vd;
   logic [1:0]    r_cd;
   logic          r_vde;
   logic [18:0]   w_cat;
   logic          w_is_ctl, w_timer_last;
   logic [1:0]    w_ctl_cd;
   logic [7:0]    w_q, w_d;

   // Older word sits in the low bits, so the window slides forward in serial time.
   assign w_cat = {raw[8:0], r_raw_d};

   always_comb begin
      w_win = w_cat[9:0];
      case (r_offset)
         4'd0:    w_win = w_cat[9:0];
         4'd1:    w_win = w_cat[10:1];
         4'd2:    w_win = w_cat[11:2];
         4'd3:    w_win = w_cat[12:3];
         4'd4:    w_win = w_cat[13:4];
         4'd5:    w_win = w_cat[14:5];
         4'd6:    w_win = w_cat[15:6];
         4'd7:    w_win = w_cat[16:7];
         4'd8:    w_win = w_cat[17:8];
         4'd9:    w_win = w_cat[18:9];
         default: w_win = w_cat[9:0];
      endcase
   end

   always_comb begin
      w_is_ctl = 1'b1;
      w_ctl_cd = 2'b00;
      case (r_sym)
         10'b1101010100: w_ctl_cd = 2'b00;
         10'b0010101011: w_ctl_cd = 2'b01;
         10'b0101010100: w_ctl_cd = 2'b10;
         10'b1010101011: w_ctl_cd = 2'b11;
         default:        w_is_ctl = 1'b0;
      endcase
      w_q    = r_sym[9] ? ~r_sym[7:0] : r_sym[7:0];
      w_d    = '0;
      w_d[0] = w_q[0];
      for (int k = 1; k < 8; k++)
         w_d[k] = r_sym[8] ? (w_q[k] ^ w_q[k-1]) : ~(w_q[k] ^ w_q[k-1]);
   end

   // A token in the same cycle as the timer limit wins: it clears the timer.
   always_comb begin
      w_state_nx   = r_state;
      w_offset_nx  = r_offset;
      w_timer_nx   = r_timer;
      w_run_nx     = r_run;
      w_relock_nx  = r_relock;
      w_run_inc    = {1'b0, r_run} + 9'd1;
      w_timer_last = (r_timer == TIMER_LAST);
      if (w_is_ctl) begin
         w_timer_nx = '0;
         if (r_state == S_HUNT) begin
            if (w_run_inc == RUN_LOCK) begin
               w_state_nx = S_LOCKED;
               w_run_nx   = 8'd0;
            end else begin
               w_run_nx = w_run_inc[7:0];
            end
         end
      end else begin
         w_run_nx = 8'd0;
         if (w_timer_last) begin
            w_timer_nx = '0;
            if (r_state == S_HUNT) begin
               w_offset_nx = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
            end else begin
               w_state_nx  = S_HUNT;
               w_relock_nx = (r_relock == 8'hFF) ? r_relock : r_relock + 8'd1;
            end
         end else begin
            w_timer_nx = r_timer + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_HUNT;
         r_offset <= 4'd0;
         r_timer  <= '0;
         r_run    <= 8'd0;
         r_relock <= 8'd0;
         r_raw_d  <= 10'd0;
         r_sym    <= 10'd0;
         r_vd     <= 8'd0;
         r_cd     <= 2'd0;
         r_vde    <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_offset <= w_offset_nx;
         r_timer  <= w_timer_nx;
         r_run    <= w_run_nx;
         r_relock <= w_relock_nx;
         r_raw_d  <= raw;
         r_sym    <= w_win;
         // Gating uses the registered lock state, so outputs trail lock by a cycle.
         if (r_state != S_LOCKED) begin
            r_vd  <= 8'd0;
            r_cd  <= 2'd0;
            r_vde <= 1'b0;
         end else if (w_is_ctl) begin
            r_vd  <= 8'd0;
            r_cd  <= w_ctl_cd;
            r_vde <= 1'b0;
         end else begin
            r_vd  <= w_d;
            r_vde <= 1'b1;
         end
      end
   end

   assign vd         = r_vd;
   assign cd         = r_cd;
   assign vde        = r_vde;
   assign locked     = (r_state == S_LOCKED);
   assign offset     = r_offset;
   assign relock_cnt = r_relock;

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: serial-stream stimulus with arbitrary bit slip, checked
// every cycle against an encoder-table reference model plus directed checks.
module tb_tmds_decoder;
   localparam int CTL_RUN = 8;
   localparam int TIMEOUT = 100;
   localparam logic [9:0] TOK00 = 10'b1101010100;
   localparam logic [9:0] TOK01 = 10'b0010101011;
   localparam logic [9:0] TOK10 = 10'b0101010100;
   localparam logic [9:0] TOK11 = 10'b1010101011;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] raw = 10'd0;
   logic [7:0] vd;
   logic [1:0] cd;
   logic       vde;
   logic       locked;
   logic [3:0] offset;
   logic [7:0] relock_cnt;

   always #20 clk = ~clk;

   tmds_decoder #(.CTL_RUN(CTL_RUN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .raw(raw), .vd(vd), .cd(cd), .vde(vde),
      .locked(locked), .offset(offset), .relock_cnt(relock_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int dec_tab[1024];
   int m_raw_d, m_sym, m_vd, m_cd, m_vde, m_locked, m_off, m_timer, m_run, m_relock;
   bit bq[$];
   logic [9:0] toks[4] = '{TOK00, TOK01, TOK10, TOK11};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Inverse table built by running the forward TMDS encoder for all bytes/modes.
   function automatic void build_tab();
      for (int d = 0; d < 256; d++) begin
         for (int xm = 0; xm < 2; xm++) begin
            int qm;
            qm = d & 1;
            for (int k = 1; k < 8; k++) begin
               int b;
               b = ((qm >> (k - 1)) & 1) ^ ((d >> k) & 1);
               if (xm == 0) b = b ^ 1;
               qm = qm | (b << k);
            end
            dec_tab[(xm << 8) | qm] = d;
            dec_tab[512 | (xm << 8) | (~qm & 255)] = d;
         end
      end
   endfunction

   function automatic int tok_cd(input int s);
      if (s == int'(TOK00)) return 0;
      if (s == int'(TOK01)) return 1;
      if (s == int'(TOK10)) return 2;
      if (s == int'(TOK11)) return 3;
      return -1;
   endfunction

   function automatic void model_step(input int r, input bit rn);
      int c, n_sym;
      if (!rn) begin
         m_raw_d = 0; m_sym = 0; m_vd = 0; m_cd = 0; m_vde = 0;
         m_locked = 0; m_off = 0; m_timer = 0; m_run = 0; m_relock = 0;
         return;
      end
      c     = tok_cd(m_sym);
      n_sym = (((r << 10) | m_raw_d) >> m_off) & 1023;
      if (m_locked == 0) begin
         m_vd = 0; m_cd = 0; m_vde = 0;
      end else if (c >= 0) begin
         m_vd = 0; m_cd = c; m_vde = 0;
      end else begin
         m_vd = dec_tab[m_sym]; m_vde = 1;
      end
      if (c >= 0) begin
         m_timer = 0;
         if (m_locked == 0) begin
            m_run++;
            if (m_run == CTL_RUN) begin
               m_locked = 1;
               m_run    = 0;
            end
         end
      end else begin
         m_run = 0;
         if (m_timer == TIMEOUT - 1) begin
            m_timer = 0;
            if (m_locked != 0) begin
               m_locked = 0;
               if (m_relock < 255) m_relock++;
            end else begin
               m_off = (m_off + 1) % 10;
            end
         end else begin
            m_timer++;
         end
      end
      m_raw_d = r;
      m_sym   = n_sym;
   endfunction

   task automatic cycle(input logic [9:0] w, input bit rn);
      logic [23:0] e;
      raw = w;
      rst = rn;
      @(posedge clk);
      model_step(int'(w), rn);
      #1;
      e = {m_vd[7:0], m_cd[1:0], m_vde[0], m_locked[0], m_off[3:0], m_relock[7:0]};
      check("outs", {vd, cd, vde, locked, offset, relock_cnt}, e);
   endtask

   task automatic do_reset();
      cycle(10'($urandom_range(0, 1023)), 1'b0);
   endtask

   task automatic start_stream(input int shift);
      bq.delete();
      for (int i = 0; i < shift; i++) bq.push_back(1'($urandom_range(0, 1)));
   endtask

   task automatic send_sym(input logic [9:0] s);
      logic [9:0] w;
      for (int i = 0; i < 10; i++) bq.push_back(s[i]);
      for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
      cycle(w, 1'b1);
   endtask

   function automatic logic [9:0] rand_data();
      logic [9:0] s;
      do s = 10'($urandom_range(0, 1023)); while (tok_cd(int'(s)) >= 0);
      return s;
   endfunction

   task automatic send_run(input logic [9:0] s, input int n);
      for (int i = 0; i < n; i++) send_sym(s);
   endtask

   task automatic send_data(input int n);
      for (int i = 0; i < n; i++) send_sym(rand_data());
   endtask

   task automatic run_random();
      for (int t = 0; t < 4; t++) begin
         int cnt;
         cnt = 0;
         start_stream($urandom_range(0, 9));
         while (cnt < 1500) begin
            int len;
            if ($urandom_range(0, 1) == 1) begin
               len = $urandom_range(1, 30);
               send_run(toks[$urandom_range(0, 3)], len);
            end else begin
               len = $urandom_range(1, 150);
               send_data(len);
            end
            cnt += len;
         end
      end
   endtask

   initial begin
      build_tab();
      // Reset state
      do_reset();
      do_reset();
      check("rst_vd", vd, 8'h00);
      check("rst_cd", cd, 2'b00);
      check("rst_vde", vde, 1'b0);
      check("rst_locked", locked, 1'b0);
      check("rst_offset", offset, 4'd0);
      check("rst_relock", relock_cnt, 8'd0);

      // Aligned stream: blanking then two data symbols
      start_stream(0);
      send_run(TOK00, 16);
      check("al_locked", locked, 1'b1);
      check("al_offset", offset, 4'd0);
      send_sym(10'h100);
      send_sym(10'h200);
      send_sym(10'h100);
      check("al_vde0", vde, 1'b1);
      check("al_vd0", vd, 8'h00);
      send_sym(10'h100);
      check("al_vd1", vd, 8'hFF);

      // Stream slipped by 3 bits: hunt must walk the offset up to 3
      do_reset();
      start_stream(3);
      for (int l = 0; l < 10; l++) begin
         send_run(TOK11, 20);
         send_data(60);
      end
      send_run(TOK11, 20);
      check("sh_locked", locked, 1'b1);
      check("sh_offset", offset, 4'd3);
      check("sh_cd", cd, 2'b11);
      check("sh_vde", vde, 1'b0);

      // Broken run of tokens must not lock; a full run must
      do_reset();
      start_stream(0);
      send_run(TOK01, 7);
      send_data(1);
      send_run(TOK01, 7);
      send_data(2);
      check("run7_locked", locked, 1'b0);
      send_run(TOK01, 8);
      send_data(2);
      check("run8_locked", locked, 1'b1);

      // Lock loss after TIMEOUT data symbols
      send_data(TIMEOUT + 3);
      check("to_locked", locked, 1'b0);
      check("to_relock", relock_cnt, 8'd1);
      check("to_offset", offset, 4'd0);
      check("to_vde", vde, 1'b0);

      // Token exactly at the timer limit keeps lock
      send_run(TOK01, 10);
      send_data(TIMEOUT - 1);
      send_sym(TOK01);
      send_data(2);
      check("tl_locked", locked, 1'b1);
      check("tl_relock", relock_cnt, 8'd1);
      send_data(TIMEOUT + 3);

      // Offset wraps 9 -> 0 with no tokens at all
      do_reset();
      start_stream(0);
      send_run(10'h3FF, 9 * TIMEOUT + 4);
      check("wrap_off9", offset, 4'd9);
      send_run(10'h3FF, TIMEOUT);
      check("wrap_off0", offset, 4'd0);

      // Relock counter saturation
      do_reset();
      start_stream(0);
      for (int i = 0; i < 256; i++) begin
         send_run(TOK10, 10);
         send_run(10'h3FF, TIMEOUT + 3);
         if (i == 254) check("sat_255", relock_cnt, 8'd255);
      end
      check("sat_hold", relock_cnt, 8'd255);
      check("sat_locked", locked, 1'b0);

      // Reset while locked at offset 5
      do_reset();
      start_stream(5);
      send_run(TOK00, 6 * TIMEOUT);
      check("r5_locked", locked, 1'b1);
      check("r5_offset", offset, 4'd5);
      do_reset();
      check("r5_rst_out", {vd, cd, vde, locked, offset, relock_cnt}, 32'd0);
      send_sym(TOK00);
      check("r5_hunt", locked, 1'b0);
      check("r5_off0", offset, 4'd0);

      // Randomized mixed traffic with changing slip
      do_reset();
      run_random();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
